// File: rtl/bfusion_pkg.sv
// Shared types and helpers for the BitFusion MAC sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bfusion_pkg;

  // Default geometry of the wrapped MAC.
  localparam int P_HEADROOM = 4;
  localparam int P_LEN_W    = 8;
  localparam int P_MAC_LAT  = 3;
  localparam int P_RST_WAIT = 2;

  // Precision modes. 2'b10 is not a legal mode and is reported as a job error.
  typedef enum logic [1:0] {
    M88 = 2'b00,
    M84 = 2'b01,
    M82 = 2'b11
  } mode_e;

  localparam logic [1:0] MODE_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_MRST,
    S_RWAIT,
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_e;

  // Sign-extend the MAC accumulator from the width that is live in this mode.
  // Upper bits above the live width are clock-gated in the MAC and may hold
  // stale data, so they are discarded rather than trusted.
  function automatic logic [31:0] sext_z(input mode_e mode, input logic [31:0] z,
                                         input int headroom);
    int               sb;
    logic signed [31:0] t;
    case (mode)
      M84:     sb = 12 + headroom;
      M82:     sb = 11 + headroom;
      default: sb = 15 + headroom;
    endcase
    t = $signed(z << (31 - sb));
    return t >>> (31 - sb);
  endfunction

endpackage

// File: rtl/bfusion_mac_seq.sv
// Job sequencer for a 1D 2-level BitFusion MAC: reset on mode change, clear, stream, drain, report.
// Latency: accept -> result = (mode change ? 1+RST_WAIT : 0) + 1 + len (+gaps) + MAC_LAT + 1 cycles.
// Backpressure: op_ready only in RUN; result held on res_valid until res_ready; cfg_ready only in IDLE.
module bfusion_mac_seq
  import bfusion_pkg::*;
#(
  parameter  int HEADROOM = P_HEADROOM,
  parameter  int LEN_W    = P_LEN_W,
  parameter  int MAC_LAT  = P_MAC_LAT,
  parameter  int RST_WAIT = P_RST_WAIT,
  localparam int ZW       = 16 + HEADROOM
) (
  input  logic             clk,
  input  logic             rst,
  // job descriptor
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  // operand stream
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [7:0]       op_w,
  // result
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ZW-1:0]    res_z,
  output logic             res_err,
  // MAC side
  output logic             mac_rst,
  output logic             mac_accu_rst,
  output logic [1:0]       mac_mode,
  output logic [31:0]      mac_a,
  output logic [7:0]       mac_w,
  input  logic [ZW-1:0]    mac_z
);

  // Shared wait counter for the post-reset settle and the pipeline drain.
  localparam int WCW = 8;

  state_e           state_q, state_d;
  mode_e            cur_mode_q, cur_mode_d;
  logic             pend_q, pend_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [ZW-1:0]    res_z_q, res_z_d;
  logic             res_err_q, res_err_d;

  // Next-state, counters and all handshake/MAC control outputs.
  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    pend_d       = pend_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    res_z_d      = res_z_q;
    res_err_d    = res_err_q;
    cfg_ready    = 1'b0;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    mac_rst      = 1'b0;
    mac_accu_rst = 1'b0;
    mac_a        = '0;
    mac_w        = '0;

    case (state_q)
      S_MRST: begin
        mac_rst = 1'b1;
        wcnt_d  = '0;
        state_d = S_RWAIT;
      end

      S_RWAIT: begin
        if (wcnt_q == WCW'(RST_WAIT - 1)) begin
          // A job that triggered the reset resumes straight into its clear.
          state_d = pend_q ? S_CLR : S_IDLE;
          pend_d  = 1'b0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          len_d = cfg_len;
          if (cfg_mode == MODE_ILLEGAL) begin
            res_z_d   = '0;
            res_err_d = 1'b1;
            state_d   = S_OUT;
          end else if (cfg_mode != cur_mode_q) begin
            // The gated upper MAC bits are stale across a mode change.
            cur_mode_d = mode_e'(cfg_mode);
            pend_d     = 1'b1;
            state_d    = S_MRST;
          end else begin
            state_d = S_CLR;
          end
        end
      end

      S_CLR: begin
        mac_accu_rst = 1'b1;
        wcnt_d       = '0;
        cnt_d        = len_q;
        state_d      = (len_q == '0) ? S_DRAIN : S_RUN;
      end

      S_RUN: begin
        op_ready = 1'b1;
        // Idle cycles feed zeros so they add nothing to the dot product.
        if (op_valid) begin
          mac_a = op_a;
          mac_w = op_w;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (wcnt_q == WCW'(MAC_LAT - 1)) begin
          res_z_d   = ZW'(sext_z(cur_mode_q, 32'(mac_z), HEADROOM));
          res_err_d = 1'b0;
          state_d   = S_OUT;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_MRST;
      end
    endcase

    // Hold the MAC in reset for the whole time the block itself is in reset.
    if (rst) begin
      mac_rst = 1'b1;
    end
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_MRST;
      cur_mode_q <= M88;
      pend_q     <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      res_z_q    <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      pend_q     <= pend_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      res_z_q    <= res_z_d;
      res_err_q  <= res_err_d;
    end
  end

  assign mac_mode = cur_mode_q;
  assign res_z    = res_z_q;
  assign res_err  = res_err_q;

endmodule

// File: tb/tb_bfusion_mac_seq.sv
// Self-checking bench for bfusion_mac_seq with a behavioural BitFusion MAC attached.
// Latency: n/a.
// Backpressure: random operand gaps and held-off result consumer.
module tb_bfusion_mac_seq;

  localparam int RST_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_len;
  logic        op_valid, op_ready;
  logic [31:0] op_a;
  logic [7:0]  op_w;
  logic        res_valid, res_ready;
  logic [19:0] res_z;
  logic        res_err;
  logic        mac_rst, mac_accu_rst;
  logic [1:0]  mac_mode;
  logic [31:0] mac_a;
  logic [7:0]  mac_w;
  logic [19:0] mac_z;

  always #5 clk = ~clk;

  bfusion_mac_seq dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_w(op_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_err(res_err),
    .mac_rst(mac_rst), .mac_accu_rst(mac_accu_rst), .mac_mode(mac_mode),
    .mac_a(mac_a), .mac_w(mac_w), .mac_z(mac_z)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural arithmetic ----------------
  function automatic int zwidth(input logic [1:0] m);
    case (m)
      2'b01:   return 17;
      2'b11:   return 16;
      default: return 20;
    endcase
  endfunction

  // Dot product of one packed word: unsigned activation bytes times signed weight fields.
  function automatic int prod_sum(input logic [1:0] m, input logic [31:0] a, input logic [7:0] w);
    int s = 0;
    int av, wv;
    case (m)
      2'b00: begin
        av = int'(a[7:0]); wv = int'(w);
        if (wv > 127) wv -= 256;
        s = av * wv;
      end
      2'b01: for (int k = 0; k < 2; k++) begin
        av = int'(a[8*k +: 8]); wv = int'(w[4*k +: 4]);
        if (wv > 7) wv -= 16;
        s += av * wv;
      end
      2'b11: for (int k = 0; k < 4; k++) begin
        av = int'(a[8*k +: 8]); wv = int'(w[2*k +: 2]);
        if (wv > 1) wv -= 4;
        s += av * wv;
      end
      default: s = 0;
    endcase
    return s;
  endfunction

  // Wrap to the mode's live width, then sign-extend to 20 bits.
  function automatic logic [19:0] wrap(input logic [1:0] m, input int s);
    int w;
    int t;
    w = zwidth(m);
    t = s <<< (32 - w);
    t = t >>> (32 - w);
    return t[19:0];
  endfunction

  // ---------------- behavioural MAC (3-cycle latency, gated upper bits) ----------------
  logic [19:0] mz;
  int          p1, p2;
  logic [19:0] mm_msk, mm_nz;

  always @(posedge clk) begin
    mm_msk = 20'((64'd1 << zwidth(mac_mode)) - 64'd1);
    if (mac_rst) begin
      mz <= '0; p1 <= 0; p2 <= 0;
    end else begin
      if (mac_accu_rst) mz <= mz & ~mm_msk;
      else begin
        mm_nz = mz + 20'(p2);
        mz <= (mz & ~mm_msk) | (mm_nz & mm_msk);
      end
      p2 <= p1;
      p1 <= prod_sum(mac_mode, mac_a, mac_w);
    end
  end
  assign mac_z = mz;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [19:0] z;
    bit          err;
    int          pulses;
    int          xfers;
    int          accs;
  } exp_t;

  exp_t        expq[$];
  exp_t        ce;
  logic [1:0]  mode_m;
  int          n_mrst, n_acc, n_xfer;
  int          cyc = 0, last_mrst = 0;
  bit          hold_prev = 0;
  logic [19:0] held_z;
  logic        held_err;

  logic [31:0] ja[64];
  logic [7:0]  jw[64];

  // Per-cycle checks of all outputs while out of reset.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (mac_rst) begin n_mrst++; last_mrst = cyc; end
      if (mac_accu_rst) begin
        n_acc++;
        if (n_mrst > 0) chk("rwait_gap", (cyc - last_mrst) == RST_WAIT + 1, cyc - last_mrst, RST_WAIT + 1);
      end
      if (op_valid && op_ready) begin
        n_xfer++;
        chk("mac_operand", mac_a == op_a && mac_w == op_w, mac_a, op_a);
      end else begin
        chk("mac_zero_operand", mac_a == 0 && mac_w == 0, mac_a, 0);
      end
      chk("mac_mode", mac_mode == mode_m, mac_mode, mode_m);
      chk("ready_exclusive", $countones({cfg_ready, op_ready, res_valid}) <= 1,
          {cfg_ready, op_ready, res_valid}, 0);
      if (res_valid) begin
        chk("res_expected", expq.size() != 0, 1, 0);
        if (hold_prev) chk("res_stable", res_z == held_z && res_err == held_err, res_z, held_z);
        if (res_ready) begin
          if (expq.size() != 0) begin
            ce = expq.pop_front();
            chk("res_z", res_z == ce.z, res_z, ce.z);
            chk("res_err", res_err == ce.err, res_err, ce.err);
            chk("mac_rst_pulses", n_mrst == ce.pulses, n_mrst, ce.pulses);
            chk("op_transfers", n_xfer == ce.xfers, n_xfer, ce.xfers);
            chk("accu_clears", n_acc == ce.accs, n_acc, ce.accs);
          end
          hold_prev = 0;
        end else begin
          hold_prev = 1; held_z = res_z; held_err = res_err;
        end
      end else begin
        if (hold_prev) chk("res_dropped", 1'b0, 0, 1);
        hold_prev = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1; cfg_valid = 0; op_valid = 0; res_ready = 0;
    expq.delete(); mode_m = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready == 0, cfg_ready, 0);
    chk("rst_op_ready", op_ready == 0, op_ready, 0);
    chk("rst_res_valid", res_valid == 0, res_valid, 0);
    chk("rst_res_z", res_z == 0, res_z, 0);
    chk("rst_res_err", res_err == 0, res_err, 0);
    chk("rst_mac_rst", mac_rst == 1, mac_rst, 1);
    chk("rst_accu_rst", mac_accu_rst == 0, mac_accu_rst, 0);
    chk("rst_mac_ops", mac_a == 0 && mac_w == 0, mac_a, 0);
    chk("rst_mac_mode", mac_mode == 0, mac_mode, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mrst_pulse", mac_rst == 1, mac_rst, 1);
    chk("mrst_cfg_ready", cfg_ready == 0, cfg_ready, 0);
    for (int k = 0; k < RST_WAIT; k++) begin
      @(negedge clk);
      chk("rwait_mac_rst", mac_rst == 0, mac_rst, 0);
      chk("rwait_cfg_ready", cfg_ready == 0, cfg_ready, 0);
    end
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready == 1, cfg_ready, 1);
    @(posedge clk); #1;
  endtask

  // Runs one job from ja/jw. Entered and left at 1 time unit after a rising edge.
  task automatic run_job(input logic [1:0] m, input int len, input int gap, input int hold,
                         input bit has_lit, input logic [19:0] lit, input bit abort);
    bit   accepted, got;
    int   i, sum;
    exp_t e;
    cfg_valid = 1; cfg_mode = m; cfg_len = 8'(len);
    accepted = 0;
    for (int b = 0; b < 200 && !accepted; b++) begin
      @(negedge clk);
      if (cfg_ready) begin
        accepted = 1; n_mrst = 0; n_acc = 0; n_xfer = 0;
      end
      @(posedge clk); #1;
    end
    cfg_valid = 0;
    chk("cfg_accept", accepted, accepted, 1);
    if (!accepted) return;

    sum = 0;
    for (int k = 0; k < len; k++) sum += prod_sum(m, ja[k], jw[k]);
    e.err    = (m == 2'b10);
    e.z      = e.err ? 20'd0 : wrap(m, sum);
    e.pulses = (!e.err && m != mode_m) ? 1 : 0;
    e.xfers  = e.err ? 0 : len;
    e.accs   = e.err ? 0 : 1;
    expq.push_back(e);
    if (!e.err) mode_m = m;

    i = 0;
    if (!e.err) begin
      for (int b = 0; b < 2000 && i < len; b++) begin
        if (abort && i >= 1) break;
        if ($urandom_range(99) < gap) begin
          op_valid = 0; op_a = $urandom; op_w = 8'($urandom);
        end else begin
          op_valid = 1; op_a = ja[i]; op_w = jw[i];
        end
        @(negedge clk);
        if (op_valid && op_ready) i++;
        @(posedge clk); #1;
      end
      op_valid = 0;
      if (abort) begin
        do_reset();
        return;
      end
      chk("ops_consumed", i == len, i, len);
    end

    // Junk operands while draining must be ignored.
    got = 0;
    for (int b = 0; b < 200 && !got; b++) begin
      op_valid = 1'($urandom_range(1)); op_a = $urandom; op_w = 8'($urandom);
      @(negedge clk);
      got = res_valid;
      if (!got) begin @(posedge clk); #1; end
    end
    chk("res_arrive", got, got, 1);
    if (!got) begin op_valid = 0; return; end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1; op_valid = 0;
      @(negedge clk);
      chk("cfg_ready_during_out", cfg_ready == 0, cfg_ready, 0);
    end
    @(posedge clk); #1;
    op_valid = 0; res_ready = 1;
    @(negedge clk);
    if (has_lit) chk("literal_z", res_z == lit, res_z, lit);
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; cfg_valid = 0; cfg_mode = 0; cfg_len = 0;
    op_valid = 0; op_a = 0; op_w = 0; res_ready = 0;
    mode_m = 2'b00; n_mrst = 0; n_acc = 0; n_xfer = 0;
    do_reset();

    // 1: mode 00, already current -> no MAC reset; 200*-3 + 10*100 = 400
    ja[0] = 32'd200; jw[0] = 8'hFD; ja[1] = 32'd10; jw[1] = 8'd100;
    run_job(2'b00, 2, 0, 0, 1, 20'h00190, 0);

    // 2: mode 11: 1*1 + 2*-2 + 3*-1 + 4*1 = -2
    ja[0] = 32'h04030201; jw[0] = 8'b01_11_10_01;
    run_job(2'b11, 1, 0, 0, 1, 20'hFFFFE, 0);

    // 3: mode 01: 5*3 + 10*-1 = 5, then a same-mode job without MAC reset
    ja[0] = 32'h00000A05; jw[0] = 8'hF3;
    run_job(2'b01, 1, 0, 0, 1, 20'd5, 0);
    run_job(2'b01, 1, 30, 1, 1, 20'd5, 0);

    // 4: mode 11, 20 words of 4 x (255 * -2) wraps in 16 bits
    for (int k = 0; k < 20; k++) begin ja[k] = 32'hFFFFFFFF; jw[k] = 8'hAA; end
    run_job(2'b11, 20, 0, 0, 1, 20'd24736, 0);

    // 5: gaps in RUN and consumer held off for 5 cycles
    for (int k = 0; k < 6; k++) begin ja[k] = $urandom; jw[k] = 8'($urandom); end
    run_job(2'b00, 6, 60, 5, 0, 20'd0, 0);

    // 6: empty job, illegal mode, reset mid-run then a clean job
    run_job(2'b00, 0, 0, 0, 1, 20'd0, 0);
    run_job(2'b10, 3, 0, 2, 1, 20'd0, 0);
    for (int k = 0; k < 8; k++) begin ja[k] = $urandom; jw[k] = 8'($urandom); end
    run_job(2'b11, 8, 20, 0, 0, 20'd0, 1);
    ja[0] = 32'd200; jw[0] = 8'hFD; ja[1] = 32'd10; jw[1] = 8'd100;
    run_job(2'b00, 2, 40, 0, 1, 20'h00190, 0);

    // Random jobs across modes, lengths, gaps and consumer stalls.
    for (int j = 0; j < 30; j++) begin
      logic [1:0] m;
      int         len;
      bit         ab;
      case ($urandom_range(9))
        0:       m = 2'b10;
        1, 2, 3: m = 2'b00;
        4, 5, 6: m = 2'b01;
        default: m = 2'b11;
      endcase
      len = $urandom_range(12);
      for (int k = 0; k < len; k++) begin ja[k] = $urandom; jw[k] = 8'($urandom); end
      ab = (j % 10 == 7) && (m != 2'b10) && (len >= 2);
      run_job(m, len, $urandom_range(50), $urandom_range(3), 0, 20'd0, ab);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", expq.size() == 0, expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
